// File: rtl/popcount_stream_pipe.sv
// Streaming popcount: registered binary adder tree (one stage per level) feeding a
// saturating per-packet accumulator, with a single global advance for flow control.

module adder_1bit_half #(
    parameter int IMPL_TYPE = 0
) (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    if (IMPL_TYPE == 0) begin : g_beh
        assign {cout, sum} = {1'b0, a} + {1'b0, b};
    end else begin : g_gate
        assign sum  = a ^ b;
        assign cout = a & b;
    end
endmodule

module adder_nbit_cout #(
    parameter int WIDTH     = 4,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    if (IMPL_TYPE == 0) begin : g_beh
        assign {cout, sum} = {1'b0, a} + {1'b0, b};
    end else begin : g_ripple
        logic [WIDTH:0] c;
        assign c[0] = 1'b0;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sum[i]  = a[i] ^ b[i] ^ c[i];
            assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        assign cout = c[WIDTH];
    end
endmodule

module popcount_stream_pipe #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 16,
    parameter int IMPL_TYPE = 0,
    localparam int LOG2W    = $clog2(WIDTH),
    localparam int CW       = LOG2W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [CW-1:0]        out_count,
    output logic [ACC_WIDTH-1:0] out_total,
    output logic                 out_sat,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);
    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        out_count_q, out_count_d;
    logic [ACC_WIDTH-1:0] out_total_q, out_total_d;
    logic                 out_sat_q, out_sat_d;
    logic                 out_last_q, out_last_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic                 adv;

    // One advance signal for the whole pipe: stages either all shift or all hold.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar k = 1; k <= LOG2W; k++) begin : g_lvl
        localparam int N = WIDTH >> k;
        logic [N-1:0][k:0] sum_q, sum_d, add_s;
        logic              vld_q, vld_d;
        logic              lst_q, lst_d;
        logic              src_vld, src_lst;

        if (k == 1) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_ha
                adder_1bit_half #(
                    .IMPL_TYPE(IMPL_TYPE)
                ) u_ha (
                    .a   (in_data[2*i]),
                    .b   (in_data[2*i+1]),
                    .sum (add_s[i][0]),
                    .cout(add_s[i][1])
                );
            end
            assign src_vld = in_valid;
            assign src_lst = in_last;
        end else begin : g_node
            for (genvar i = 0; i < N; i++) begin : g_add
                adder_nbit_cout #(
                    .WIDTH    (k),
                    .IMPL_TYPE(IMPL_TYPE)
                ) u_add (
                    .a   (g_lvl[k-1].sum_q[2*i]),
                    .b   (g_lvl[k-1].sum_q[2*i+1]),
                    .sum (add_s[i][k-1:0]),
                    .cout(add_s[i][k])
                );
            end
            assign src_vld = g_lvl[k-1].vld_q;
            assign src_lst = g_lvl[k-1].lst_q;
        end

        always_comb begin
            sum_d = sum_q;
            vld_d = vld_q;
            lst_d = lst_q;
            if (adv) begin
                sum_d = add_s;
                vld_d = src_vld;
                lst_d = src_lst;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                vld_q <= 1'b0;
                lst_q <= 1'b0;
            end else begin
                sum_q <= sum_d;
                vld_q <= vld_d;
                lst_q <= lst_d;
            end
        end
    end

    logic [CW-1:0]        tail_cnt;
    logic                 tail_vld;
    logic                 tail_lst;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] total;
    logic                 sat;

    assign tail_cnt = g_lvl[LOG2W].sum_q[0];
    assign tail_vld = g_lvl[LOG2W].vld_q;
    assign tail_lst = g_lvl[LOG2W].lst_q;

    // Extra carry bit detects overflow of the running total.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - CW){1'b0}}, tail_cnt};
    assign ovf     = sum_ext[ACC_WIDTH];
    assign total   = ovf ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
    assign sat     = sat_q || ovf;

    always_comb begin
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_total_d = out_total_q;
        out_sat_d   = out_sat_q;
        out_last_d  = out_last_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        if (adv) begin
            out_valid_d = tail_vld;
            if (tail_vld) begin
                out_count_d = tail_cnt;
                out_total_d = total;
                out_sat_d   = sat;
                out_last_d  = tail_lst;
                if (tail_lst) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                end else begin
                    acc_d = total;
                    sat_d = sat;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_total_q <= '0;
            out_sat_q   <= 1'b0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_total_q <= out_total_d;
            out_sat_q   <= out_sat_d;
            out_last_q  <= out_last_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_total = out_total_q;
    assign out_sat   = out_sat_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_popcount_stream_pipe.sv
// Bench for popcount_stream_pipe: five instances of different width/accumulator size
// checked against a queue-based reference model of counts, group totals and latency.

module tb_popcount_stream_pipe;
    localparam int NI = 5;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [15:0] tot;
        logic        sat;
        logic        lst;
        int          cyc;
        int          stl;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic        vin, lin, rdy;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int wid [NI] = '{32, 32, 8, 2, 64};
    int aw  [NI] = '{16, 6, 16, 16, 16};
    int lg  [NI] = '{5, 5, 3, 1, 6};

    beat_t  exp_q [NI][$];
    beat_t  log_q [NI][$];
    longint acc_m [NI];
    bit     sat_m [NI];
    int     stalls [NI];
    bit     hold_v [NI];
    beat_t  held [NI];

    int chk_cnt = 0;
    int err_cnt = 0;

    logic       ir0, ov0, os0, ol0;
    logic [5:0] oc0;
    logic [15:0] ot0;
    logic       ir1, ov1, os1, ol1;
    logic [5:0] oc1;
    logic [5:0] ot1;
    logic       ir2, ov2, os2, ol2;
    logic [3:0] oc2;
    logic [15:0] ot2;
    logic       ir3, ov3, os3, ol3;
    logic [1:0] oc3;
    logic [15:0] ot3;
    logic       ir4, ov4, os4, ol4;
    logic [6:0] oc4;
    logic [15:0] ot4;

    popcount_stream_pipe #(.WIDTH(32), .ACC_WIDTH(16), .IMPL_TYPE(0)) u_dut (
        .clk(clk), .rst(rst), .in_data(din[31:0]), .in_valid(vin), .in_last(lin),
        .in_ready(ir0), .out_count(oc0), .out_total(ot0), .out_sat(os0),
        .out_last(ol0), .out_valid(ov0), .out_ready(rdy));

    popcount_stream_pipe #(.WIDTH(32), .ACC_WIDTH(6), .IMPL_TYPE(1)) u_sat (
        .clk(clk), .rst(rst), .in_data(din[31:0]), .in_valid(vin), .in_last(lin),
        .in_ready(ir1), .out_count(oc1), .out_total(ot1), .out_sat(os1),
        .out_last(ol1), .out_valid(ov1), .out_ready(rdy));

    popcount_stream_pipe #(.WIDTH(8), .ACC_WIDTH(16), .IMPL_TYPE(0)) u_w8 (
        .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vin), .in_last(lin),
        .in_ready(ir2), .out_count(oc2), .out_total(ot2), .out_sat(os2),
        .out_last(ol2), .out_valid(ov2), .out_ready(1'b1));

    popcount_stream_pipe #(.WIDTH(2), .ACC_WIDTH(16), .IMPL_TYPE(1)) u_w2 (
        .clk(clk), .rst(rst), .in_data(din[1:0]), .in_valid(vin), .in_last(lin),
        .in_ready(ir3), .out_count(oc3), .out_total(ot3), .out_sat(os3),
        .out_last(ol3), .out_valid(ov3), .out_ready(1'b1));

    popcount_stream_pipe #(.WIDTH(64), .ACC_WIDTH(16), .IMPL_TYPE(0)) u_w64 (
        .clk(clk), .rst(rst), .in_data(din), .in_valid(vin), .in_last(lin),
        .in_ready(ir4), .out_count(oc4), .out_total(ot4), .out_sat(os4),
        .out_last(ol4), .out_valid(ov4), .out_ready(1'b1));

    task automatic check(input string tag, input longint obs, input longint exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] data_of(input beat_t b);
        return {b.cnt, b.tot, b.sat, b.lst};
    endfunction

    task automatic flush_all();
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            acc_m[i]  = 0;
            sat_m[i]  = 1'b0;
            hold_v[i] = 1'b0;
        end
    endtask

    task automatic monitor(input int i, input logic ir, input logic [63:0] d,
                           input logic ov, input logic ordy, input logic [7:0] oc,
                           input logic [15:0] ot, input logic os, input logic ol);
        beat_t  e, o;
        longint c, s, mx, t;
        bit     ovf;
        o = '0;
        o.cnt = oc; o.tot = ot; o.sat = os; o.lst = ol;
        if (ov) begin
            if (hold_v[i])
                check($sformatf("stable_i%0d", i), data_of(o), data_of(held[i]));
            if (!ordy) begin
                check($sformatf("in_ready_stall_i%0d", i), ir, 0);
                held[i]   = o;
                hold_v[i] = 1'b1;
                stalls[i]++;
            end else begin
                hold_v[i] = 1'b0;
                check($sformatf("spurious_i%0d", i), exp_q[i].size() > 0, 1);
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    check($sformatf("count_i%0d", i), o.cnt, e.cnt);
                    check($sformatf("total_i%0d", i), o.tot, e.tot);
                    check($sformatf("sat_i%0d", i), o.sat, e.sat);
                    check($sformatf("last_i%0d", i), o.lst, e.lst);
                    check($sformatf("latency_i%0d", i), cyc - e.cyc,
                          lg[i] + 1 + stalls[i] - e.stl);
                    log_q[i].push_back(o);
                end
            end
        end else begin
            hold_v[i] = 1'b0;
        end
        if (vin && ir) begin
            e   = '0;
            c   = $countones(d);
            s   = acc_m[i] + c;
            mx  = (64'd1 << aw[i]) - 1;
            ovf = s > mx;
            t   = ovf ? mx : s;
            e.cnt = c[7:0];
            e.tot = t[15:0];
            e.sat = sat_m[i] | ovf;
            e.lst = lin;
            e.cyc = cyc;
            e.stl = stalls[i];
            if (lin) begin
                acc_m[i] = 0;
                sat_m[i] = 1'b0;
            end else begin
                acc_m[i] = t;
                sat_m[i] = e.sat;
            end
            exp_q[i].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            flush_all();
        end else begin
            monitor(0, ir0, {32'b0, din[31:0]}, ov0, rdy, {2'b0, oc0}, ot0, os0, ol0);
            monitor(1, ir1, {32'b0, din[31:0]}, ov1, rdy, {2'b0, oc1}, {10'b0, ot1}, os1, ol1);
            monitor(2, ir2, {56'b0, din[7:0]}, ov2, 1'b1, {4'b0, oc2}, ot2, os2, ol2);
            monitor(3, ir3, {62'b0, din[1:0]}, ov3, 1'b1, {6'b0, oc3}, ot3, os3, ol3);
            monitor(4, ir4, din, ov4, 1'b1, {1'b0, oc4}, ot4, os4, ol4);
        end
    end

    task automatic send(input logic [63:0] d, input logic l);
        int guard = 0;
        din = d; lin = l; vin = 1'b1;
        @(negedge clk);
        while (!ir0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send_accept", ir0, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int n);
        vin = 1'b0; lin = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input int i, input int back, input string tag,
                             input int c, input int t, input int s, input int l);
        beat_t o;
        check({tag, "_avail"}, log_q[i].size() >= back, 1);
        if (log_q[i].size() >= back) begin
            o = log_q[i][log_q[i].size() - back];
            check({tag, "_cnt"}, o.cnt, c);
            check({tag, "_tot"}, o.tot, t);
            check({tag, "_sat"}, o.sat, s);
            check({tag, "_last"}, o.lst, l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int guard;
        vin = 1'b0; lin = 1'b0; din = '0; rdy = 1'b1;
        for (int i = 0; i < NI; i++) stalls[i] = 0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", ov0, 0);
        check("rst_out_count", oc0, 0);
        check("rst_out_total", ot0, 0);
        check("rst_out_sat", os0, 0);
        check("rst_out_last", ol0, 0);
        check("rst_in_ready", ir0, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // single beat, full word
        send(64'hFFFF_FFFF, 1'b1);
        drain(20);
        check_log(0, 1, "single", 32, 32, 0, 1);

        // back-to-back group then a fresh group
        send(64'h0000_0000, 1'b0);
        send(64'h5555_5555, 1'b0);
        send(64'h8000_0001, 1'b1);
        send(64'h0000_000F, 1'b1);
        drain(20);
        check_log(0, 4, "b2b0", 0, 0, 0, 0);
        check_log(0, 3, "b2b1", 16, 16, 0, 0);
        check_log(0, 2, "b2b2", 2, 18, 0, 1);
        check_log(0, 1, "b2b3", 4, 4, 0, 1);

        // backpressure: 5-cycle hold in the middle of 10 beats
        n0 = log_q[0].size();
        fork
            begin
                for (int b = 0; b < 10; b++)
                    send({$urandom, $urandom}, b == 9);
            end
            begin
                repeat (8) @(posedge clk);
                #1 rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        drain(25);
        check("bp_beats_out", log_q[0].size() - n0, 10);

        // saturation on the 6-bit accumulator instance
        send(64'hFFFF_FFFF, 1'b0);
        send(64'hFFFF_FFFF, 1'b0);
        send(64'hFFFF_FFFF, 1'b1);
        send(64'h0000_0001, 1'b1);
        drain(20);
        check_log(1, 4, "sat0", 32, 32, 0, 0);
        check_log(1, 3, "sat1", 32, 63, 1, 0);
        check_log(1, 2, "sat2", 32, 63, 1, 1);
        check_log(1, 1, "sat3", 1, 1, 0, 1);
        check_log(0, 2, "nosat2", 32, 96, 0, 1);

        // reset while three beats are in flight and the first is stalled at the output
        rdy = 1'b0;
        send(64'h0000_0001, 1'b0);
        send(64'h0000_0003, 1'b0);
        send(64'h0000_0007, 1'b0);
        vin = 1'b0;
        guard = 0;
        while (!ov0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("stall_out_valid", ov0, 1);
        n0 = log_q[0].size();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", ov0, 0);
        check("midrst_out_total", ot0, 0);
        check("midrst_out_count", oc0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = 1'b1;
        drain(15);
        check("midrst_no_old_beats", log_q[0].size() - n0, 0);
        send(64'h0000_0003, 1'b1);
        drain(20);
        check_log(0, 1, "postrst", 2, 2, 0, 1);

        // width sweep: exhaustive 2-bit patterns, then random beats with random stalls
        for (int d = 0; d < 4; d++)
            send(d, d == 3);
        fork
            begin
                for (int b = 0; b < 30; b++)
                    send({$urandom, $urandom}, ($urandom_range(0, 3) == 0));
                send({$urandom, $urandom}, 1'b1);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 rdy = ($urandom_range(0, 3) != 0);
                end
                rdy = 1'b1;
            end
        join
        rdy = 1'b1;
        drain(30);
        for (int i = 0; i < NI; i++)
            check($sformatf("drained_i%0d", i), exp_q[i].size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
